// File: rtl/shift_unit_seq.sv
// ---------------------------------------------------------------------------
// shift_unit_seq
//
// Iterative multi-cycle shifter. An accepted request captures the operand,
// the operation and the shift amount, then applies one 1-bit step per clock
// until the amount is used up. done pulses for one cycle when the result is
// final. The result is held until the next accepted request.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   start    - request, sampled only in IDLE or DONE
//   op       - 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, others pass-through
//   data_in  - operand, captured on an accepted start
//   shamt    - shift amount, captured on an accepted start
//   busy     - high while shifting
//   done     - one-cycle pulse, result valid
//   result   - working/result register
// ---------------------------------------------------------------------------
module shift_unit_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         op_q;
    logic [SHAMT_W-1:0] count;
    logic               accept;
    logic               op_legal;
    logic [SHAMT_W-1:0] load_count;
    logic [WIDTH-1:0]   step_value;

    // A new request can only be taken when no shift is in flight.
    always_comb begin
        accept     = 1'b0;
        op_legal   = 1'b0;
        load_count = '0;
        accept     = ((state == IDLE) || (state == DONE)) && start;
        op_legal   = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
                     (op == OP_ROL) || (op == OP_ROR);
        // Pass-through ops load a zero amount so they finish immediately.
        load_count = op_legal ? shamt : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = (load_count == '0) ? DONE : SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                // The edge that consumes the last step lands in DONE.
                if (count <= SHAMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // One 1-bit step of the captured operation.
    always_comb begin
        step_value = result;
        case (op_q)
            OP_SLL:  step_value = {result[WIDTH-2:0], 1'b0};
            OP_SRL:  step_value = {1'b0, result[WIDTH-1:1]};
            OP_SRA:  step_value = {result[WIDTH-1], result[WIDTH-1:1]};
            OP_ROL:  step_value = {result[WIDTH-2:0], result[WIDTH-1]};
            OP_ROR:  step_value = {result[0], result[WIDTH-1:1]};
            default: step_value = result;
        endcase
    end

    // Datapath registers: capture on accept, step while shifting, hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            op_q   <= '0;
            count  <= '0;
        end else if (accept) begin
            result <= data_in;
            op_q   <= op;
            count  <= load_count;
        end else if (state == SHIFT) begin
            result <= step_value;
            count  <= count - SHAMT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_seq
//
// Self-checking bench for shift_unit_seq. A behavioural model tracks how many
// single-bit steps have been applied to the captured operand and derives the
// expected result with plain shift arithmetic; a compare process checks busy,
// done and result against it every cycle. Directed requests with literal
// expected values pin the model, then randomized requests follow.
// ---------------------------------------------------------------------------
module tb_shift_unit_seq;

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Model state: captured operand/op, total steps required, steps applied.
    logic [31:0] m_data;
    logic [2:0]  m_op;
    int          m_total;
    int          m_steps;
    bit          m_in_shift;
    bit          m_done;

    shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference value of an operand after k single-bit steps of an operation.
    function automatic logic [31:0] shift_ref(input logic [31:0] d, input logic [2:0] o, input int k);
        logic [31:0] r;
        r = d;
        case (o)
            OP_SLL: r = d << k;
            OP_SRL: r = d >> k;
            OP_SRA: r = $signed(d) >>> k;
            OP_ROL: r = (k == 0) ? d : ((d << k) | (d >> (32 - k)));
            OP_ROR: r = (k == 0) ? d : ((d >> k) | (d << (32 - k)));
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic bit op_is_legal(input logic [2:0] o);
        return (o >= 3'd1) && (o <= 3'd5);
    endfunction

    // Behavioural model: counts steps towards the captured amount.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data     = 32'h0;
            m_op       = 3'b000;
            m_total    = 0;
            m_steps    = 0;
            m_in_shift = 0;
            m_done     = 0;
        end else if (m_in_shift) begin
            m_steps = m_steps + 1;
            if (m_steps >= m_total) begin
                m_in_shift = 0;
                m_done     = 1;
            end
        end else if (start) begin
            m_data  = data_in;
            m_op    = op;
            m_total = op_is_legal(op) ? int'(shamt) : 0;
            m_steps = 0;
            if (m_total == 0) begin
                m_done = 1;
            end else begin
                m_in_shift = 1;
                m_done     = 0;
            end
        end else begin
            m_done = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle away from the edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_busy", 32'(busy), 32'(m_in_shift));
            checkOutput("cyc_done", 32'(done), 32'(m_done));
            checkOutput("cyc_result", result, shift_ref(m_data, m_op, m_steps));
        end
    end

    // Presents a request for exactly one edge, then scrambles the inputs.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s);
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = s;
        @(posedge clk);
        #2;
        start   = 1'b0;
        op      = 3'($urandom);
        data_in = $urandom;
        shamt   = 5'($urandom);
    endtask

    // Waits (bounded) for done, counting busy cycles; optionally hammers start.
    task automatic wait_done(input bit hammer, output int busy_cnt, output bit got);
        busy_cnt = 0;
        got      = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                if (hammer) start = 1'b0;
            end else if (busy) begin
                busy_cnt = busy_cnt + 1;
                if (hammer) begin
                    start   = 1'b1;
                    op      = 3'($urandom);
                    data_in = $urandom;
                    shamt   = 5'($urandom);
                end
            end
        end
        if (!got) begin
            start = 1'b0;
            checkOutput("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] exp_result,
                          input int exp_busy, input bit hammer);
        int bc;
        bit got;
        @(posedge clk);
        #2;
        applyStimulus(o, d, s);
        wait_done(hammer, bc, got);
        checkOutput({name, "_result"}, result, exp_result);
        checkOutput({name, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    endtask

    initial begin
        int bc;
        bit got;
        int done_seen;
        reset   = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        data_in = 32'h0;
        shamt   = 5'd0;

        // Reset state.
        @(negedge clk);
        check_en = 1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // Directed requests with hand-computed results.
        run_op("sll4", OP_SLL, 32'h0000_00F0, 5'd4, 32'h0000_0F00, 4, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("sll4_hold", result, 32'h0000_0F00);
        end
        run_op("sra4", OP_SRA, 32'h8000_0010, 5'd4, 32'hF800_0001, 4, 1'b0);
        run_op("srl4", OP_SRL, 32'h8000_0010, 5'd4, 32'h0800_0001, 4, 1'b0);
        run_op("sra31", OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31, 1'b0);
        run_op("rol8", OP_ROL, 32'h1234_5678, 5'd8, 32'h3456_7812, 8, 1'b0);
        run_op("ror4", OP_ROR, 32'h1234_5678, 5'd4, 32'h8123_4567, 4, 1'b0);
        run_op("sll0", OP_SLL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 0, 1'b0);
        run_op("illegal", 3'b111, 32'hDEAD_BEEF, 5'd9, 32'hDEAD_BEEF, 0, 1'b0);
        run_op("hammer", OP_SLL, 32'h0000_00F0, 5'd4, 32'h0000_0F00, 4, 1'b1);

        // Back-to-back: new request accepted on the edge that leaves DONE.
        @(posedge clk);
        #2;
        applyStimulus(OP_SLL, 32'h0000_0003, 5'd2);
        wait_done(1'b0, bc, got);
        checkOutput("b2b_first_result", result, 32'h0000_000C);
        applyStimulus(OP_SRL, 32'hFFFF_FFFF, 5'd16);
        wait_done(1'b0, bc, got);
        checkOutput("b2b_result", result, 32'h0000_FFFF);
        checkOutput("b2b_busy_cycles", 32'(bc), 32'd16);

        // Reset during the fifth busy cycle of a long shift.
        @(posedge clk);
        #2;
        applyStimulus(OP_SLL, 32'h0000_0001, 5'd20);
        repeat (4) @(posedge clk);
        #3;
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midop_reset_busy", 32'(busy), 32'd0);
        checkOutput("midop_reset_done", 32'(done), 32'd0);
        checkOutput("midop_reset_result", result, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) done_seen = done_seen + 1;
        end
        checkOutput("post_reset_done_pulses", 32'(done_seen), 32'd0);
        checkOutput("post_reset_result", result, 32'h0);

        // Randomized requests, mixing idle gaps, back-to-back and start hammering.
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  ro;
            logic [31:0] rd;
            logic [4:0]  rs;
            int          gap;
            ro  = 3'($urandom);
            rd  = $urandom;
            rs  = 5'($urandom);
            gap = $urandom_range(0, 2);
            if (gap > 0 || n == 0) begin
                repeat (gap + 1) @(posedge clk);
                #2;
            end
            applyStimulus(ro, rd, rs);
            wait_done(1'($urandom), bc, got);
            checkOutput("rnd_result", result, shift_ref(rd, ro, int'(rs)));
            checkOutput("rnd_busy_cycles", 32'(bc), op_is_legal(ro) ? 32'(rs) : 32'd0);
        end

        @(posedge clk);
        #2;
        repeat (2) @(negedge clk);
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
